dkong_audio_out: RTL and testbench
==================================

# dkong_audio_out

Output stage downstream of the Donkey Kong soundboard mixer. It takes the saturated 16-bit signed mix and samples it once per 48 kHz frame. It then applies an optional DC-blocking high-pass, mute and a 3-bit shift attenuation, and serialises the result as mono-duplicated I2S (MCLK 256fs, BCLK 64fs, 16-bit MSB-first in 32-bit slots) for the board DAC. All timing is derived from the 24.576 MHz system clock by a single 9-bit frame counter.

## Interface
- none — frame length is fixed at 512 clocks (24.576 MHz / 48 kHz); no parameters.
- W_CLK_24576M  in  1  system clock, 24.576 MHz; only clock.
- reset  in  1  synchronous, active-high reset.
- I_SOUND_DAT  in  16  signed mix sample; held stable for the whole frame.
- I_DCBLK_EN  in  1  1 = DC blocker in path, 0 = bypass (filter state still updates).
- I_MUTE  in  1  1 = force sample word to 0.
- I_ATTEN  in  3  arithmetic right shift 0..7 applied after the filter.
- O_MCLK  out  1  12.288 MHz master clock.
- O_BCLK  out  1  3.072 MHz bit clock.
- O_LRCK  out  1  0 = left slot, 1 = right slot.
- O_SDATA  out  1  serial data; changes on BCLK falling edge.
- O_SAMPLE_STB  out  1  one-clock pulse on input capture.

## Operation
- **Frame counter `cnt`:** 9 bits, 0..511, +1 every clock, wraps 511→0.
- **Clock outputs:** O_MCLK = cnt[0], O_BCLK = cnt[2], O_LRCK = cnt[8], all driven directly from counter flops.
- **Slot index:** k = cnt[7:3], 0..31, within each half-frame.
- **Input pipeline:**
  - cnt==508: capture x = I_SOUND_DAT and pulse O_SAMPLE_STB.
  - cnt==509: DC-filter step.
  - cnt==510: mute/attenuate.
  - cnt==511: load output word W.
- **DC blocker (cnt==509):**
  - s = x − x_prev + y_prev − (y_prev >>> 10), evaluated at 18-bit signed width.
  - y = s saturated to [−32768, 32767].
  - Update x_prev ← x and y_prev ← y; feedback uses the saturated value.
  - `>>>` is arithmetic, i.e. floor. Consequences: a positive residual stalls at 1023; a negative residual decays to 0.
- **Path select:** f = I_DCBLK_EN ? y : x, with I_DCBLK_EN sampled at cnt==509.
- **Attenuation (cnt==510):** a = I_MUTE ? 0 : (f >>> I_ATTEN), sign-extending; I_MUTE and I_ATTEN sampled at this cycle.
- **Output word:** W ← a at cnt==511. W stays constant for the following frame, cnt 0..511.
- **Serialisation, both halves identical (mono):**
  - Slot k = 1..16 carries W[16−k], MSB first.
  - Slots 0 and 17..31 carry 0.
  - Standard I2S one-BCLK delay after each LRCK edge.

## Timing
- **Reset values:** all outputs 0. cnt, x_prev, y_prev, W and every pipeline register are 0.
- **First clock after reset released:** cnt=1.
- **O_SDATA:** registered. It updates on the same clock edge that makes cnt[2:0]==0, so it is stable through each BCLK high phase (cnt[2:0]=4..7), where the DAC samples.
- **Latency:** a sample captured at cnt==508 drives the MSB in the left slot k=1, cnt 8..15 of the next frame. That is 12 clocks from capture to MSB.
- **First frame after reset:** transmits all zeros.
- **Reset mid-frame:** synchronous. Counter, filter state and W clear on the same edge; there is no partial-frame recovery.
- **Input changes:** changes to I_SOUND_DAT outside cnt==508 are ignored. Control inputs take effect only at their sample cycles and never alter W mid-frame.
- **Clock edges:** O_LRCK toggles only where cnt[7:0]==0, coincident with a BCLK falling edge. MCLK, BCLK and LRCK stay phase-locked forever; there is no drift or resync logic.

## Test plan
- **Reset and clock periods:** hold reset 10 clocks, then release. Require all outputs 0 during reset. After release, O_BCLK period = 8 clocks, O_LRCK period = 512 with 256 high, O_MCLK period = 2, and O_SAMPLE_STB high only at cnt==508.
- **Basic serialisation:** I_SOUND_DAT=0x1234, DCBLK off, ATTEN=0, MUTE=0. Decoding on BCLK rising edges in the frame after capture gives left=right=0x1234 in slots 1..16 and zeros elsewhere.
- **Attenuation and mute:** input 0x8000 with ATTEN=3 gives W=0xF000. Assert MUTE in the next frame and the following word is 0x0000.
- **DC step response:** DCBLK on, step input 0→0x4000 and hold.
  - Successive words are 0x4000, 0x3FF0, decreasing thereafter.
  - Within 10000 frames the word settles at exactly 1023 (0x03FF).
  - Then step back to 0; the output goes negative and decays to exactly 0.
- **DC saturation:** DCBLK on, input 0x7FFF for one frame, then 0x8000. Output words are 0x7FFF then 0x8000 (saturated from −32799).
- **Reset mid-frame:** assert reset at cnt==130 for one clock. On the next edge the outputs are 0 and cnt=0; the next transmitted frame is all zeros; y_prev is cleared.

Source files
------------

// File: rtl/dkong_audio_out.sv
// I2S output stage for the Donkey Kong sound mix: one sample per 512-clock frame,
// optional DC blocker, mute and shift attenuation, mono-duplicated 16-bit I2S.
module dkong_audio_out (
  input  logic               W_CLK_24576M,
  input  logic               reset,
  input  logic signed [15:0] I_SOUND_DAT,
  input  logic               I_DCBLK_EN,
  input  logic               I_MUTE,
  input  logic [2:0]         I_ATTEN,
  output logic               O_MCLK,
  output logic               O_BCLK,
  output logic               O_LRCK,
  output logic               O_SDATA,
  output logic               O_SAMPLE_STB
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = 18;

  logic [8:0]               cnt;
  logic                     stb;
  logic                     sdata;
  logic signed [DATA_W-1:0] x_p0;
  logic signed [DATA_W-1:0] x_prev;
  logic signed [DATA_W-1:0] y_prev;
  logic signed [DATA_W-1:0] f_p1;
  logic signed [DATA_W-1:0] a_p2;
  logic signed [DATA_W-1:0] w_p3;
  logic signed [ACC_W-1:0]  dc_sum;
  logic signed [DATA_W-1:0] y_next;
  logic [4:0]               slot_nx;
  logic [3:0]               bit_idx;
  logic                     slot_bit;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 18'sd32767)
      return 16'sh7FFF;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] atten_shift(input logic signed [DATA_W-1:0] v,
                                                          input logic [2:0] sh);
    return v >>> sh;
  endfunction

  // Leaky differentiator; 18 bits holds the worst-case sum before saturation
  assign dc_sum = ACC_W'(x_p0) - ACC_W'(x_prev) + ACC_W'(y_prev) - ACC_W'(y_prev >>> 10);
  assign y_next = sat16(dc_sum);

  // Bit for the slot that starts on the next clock edge; only used when cnt[2:0]==7
  assign slot_nx = cnt[7:3] + 5'd1;
  assign bit_idx = 4'(5'd16 - slot_nx);

  always_comb begin
    slot_bit = 1'b0;
    if (slot_nx != 5'd0 && slot_nx <= 5'd16)
      slot_bit = w_p3[bit_idx];
  end

  always_ff @(posedge W_CLK_24576M) begin
    if (reset) begin
      cnt    <= '0;
      stb    <= 1'b0;
      sdata  <= 1'b0;
      x_p0   <= '0;
      x_prev <= '0;
      y_prev <= '0;
      f_p1   <= '0;
      a_p2   <= '0;
      w_p3   <= '0;
    end else begin
      cnt <= cnt + 9'd1;
      stb <= (cnt == 9'd507);

      // p0: capture
      if (cnt == 9'd508)
        x_p0 <= I_SOUND_DAT;

      // p1: DC blocker step; state advances even when bypassed
      if (cnt == 9'd509) begin
        x_prev <= x_p0;
        y_prev <= y_next;
        f_p1   <= I_DCBLK_EN ? y_next : x_p0;
      end

      // p2: mute / attenuate
      if (cnt == 9'd510)
        a_p2 <= I_MUTE ? '0 : atten_shift(f_p1, I_ATTEN);

      // p3: output word, held for the whole next frame
      if (cnt == 9'd511)
        w_p3 <= a_p2;

      if (cnt[2:0] == 3'd7)
        sdata <= slot_bit;
    end
  end

  assign O_MCLK       = cnt[0];
  assign O_BCLK       = cnt[2];
  assign O_LRCK       = cnt[8];
  assign O_SDATA      = sdata;
  assign O_SAMPLE_STB = stb;

endmodule

// File: tb/tb_dkong_audio_out.sv
// Bench for dkong_audio_out: tracks the frame position independently, decodes the
// I2S stream and compares each word with a frame-level arithmetic model.
module tb_dkong_audio_out;

  logic               clk;
  logic               reset;
  logic signed [15:0] sound;
  logic               dcblk;
  logic               mute;
  logic [2:0]         atten;
  logic               mclk_o, bclk_o, lrck_o, sdata_o, stb_o;

  int          checks;
  int          errors;
  int          tcnt;
  logic        prev_sd;
  int          xp, yp;
  logic [15:0] exp_w;
  logic [15:0] got_w;
  logic [15:0] prev_w;

  dkong_audio_out dut (
    .W_CLK_24576M (clk),
    .reset        (reset),
    .I_SOUND_DAT  (sound),
    .I_DCBLK_EN   (dcblk),
    .I_MUTE       (mute),
    .I_ATTEN      (atten),
    .O_MCLK       (mclk_o),
    .O_BCLK       (bclk_o),
    .O_LRCK       (lrck_o),
    .O_SDATA      (sdata_o),
    .O_SAMPLE_STB (stb_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Frame-level model: computes the word the DUT will transmit one frame later
  task automatic model_step(input int x, input logic dc, input logic mu, input int at);
    int s, y, f, a;
    s = x - xp + yp - fdiv(yp, 1024);
    if (s > 32767) y = 32767;
    else if (s < -32768) y = -32768;
    else y = s;
    xp = x;
    yp = y;
    f = dc ? y : x;
    a = mu ? 0 : fdiv(f, 1 << at);
    exp_w = a[15:0];
  endtask

  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) tcnt = 0;
    else tcnt = (tcnt + 1) % 512;
    check("mclk", 32'(mclk_o), 32'(tcnt[0]));
    check("bclk", 32'(bclk_o), 32'(tcnt[2]));
    check("lrck", 32'(lrck_o), 32'(tcnt[8]));
    check("stb", 32'(stb_o), 32'(tcnt == 508));
    if (r)
      check("sdata_rst", 32'(sdata_o), 32'd0);
    else if (tcnt % 8 != 0)
      check("sdata_hold", 32'(sdata_o), 32'(prev_sd));
    prev_sd = sdata_o;
  endtask

  task automatic run_frame(output logic [15:0] l, output logic [15:0] r, output logic [31:0] extra);
    logic [31:0] lb, rb;
    int k;
    lb = '0;
    rb = '0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (tcnt % 8 == 4) begin
        k = (tcnt / 8) % 32;
        if (tcnt < 256) lb[31-k] = sdata_o;
        else rb[31-k] = sdata_o;
      end
    end
    l = lb[30:15];
    r = rb[30:15];
    extra = {lb[31], lb[14:0], rb[31], rb[14:0]};
  endtask

  task automatic do_frame(input logic signed [15:0] x, input logic dc, input logic mu,
                          input logic [2:0] at, input string tag);
    logic [15:0] gl, gr;
    logic [31:0] ex;
    int xi;
    sound = x;
    dcblk = dc;
    mute  = mu;
    atten = at;
    run_frame(gl, gr, ex);
    check({tag, "_left"}, 32'(gl), 32'(exp_w));
    check({tag, "_right"}, 32'(gr), 32'(exp_w));
    check({tag, "_unused_slots"}, ex, 32'd0);
    prev_w = got_w;
    got_w  = gl;
    xi = x;
    model_step(xi, dc, mu, int'(at));
  endtask

  initial begin
    checks = 0; errors = 0; tcnt = 0; prev_sd = 1'b0;
    xp = 0; yp = 0; exp_w = '0; got_w = '0; prev_w = '0;
    reset = 1'b1; sound = '0; dcblk = 1'b0; mute = 1'b0; atten = '0;

    repeat (10) tick();
    reset = 1'b0;

    // First frame after reset, DC blocker settling with a small step
    do_frame(16'sh0410, 1'b1, 1'b0, 3'd0, "first");
    check("first_frame_zero", 32'(got_w), 32'd0);
    repeat (19) do_frame(16'sh0410, 1'b1, 1'b0, 3'd0, "settle");
    check("settle_1023", 32'(got_w), 32'h03FF);
    do_frame(16'sh0410, 1'b1, 1'b0, 3'd0, "settle_hold");
    check("settle_hold_1023", 32'(got_w), 32'h03FF);

    // Step back to zero: negative residual decays to exactly zero
    do_frame(16'sh0000, 1'b1, 1'b0, 3'd0, "down");
    do_frame(16'sh0000, 1'b1, 1'b0, 3'd0, "down");
    check("down_negative", 32'(got_w), 32'h0000FFEF);
    repeat (18) do_frame(16'sh0000, 1'b1, 1'b0, 3'd0, "decay");
    check("decay_zero", 32'(got_w), 32'd0);

    // Large step from clean filter state
    do_frame(16'sh4000, 1'b1, 1'b0, 3'd0, "step");
    do_frame(16'sh4000, 1'b1, 1'b0, 3'd0, "step");
    check("step_4000", 32'(got_w), 32'h4000);
    do_frame(16'sh4000, 1'b1, 1'b0, 3'd0, "step");
    check("step_3ff0", 32'(got_w), 32'h3FF0);
    do_frame(16'sh4000, 1'b1, 1'b0, 3'd0, "step");
    check("step_decreasing", 32'(got_w < prev_w), 32'd1);

    // Bypass serialisation
    do_frame(16'sh1234, 1'b0, 1'b0, 3'd0, "basic");
    do_frame(16'sh1234, 1'b0, 1'b0, 3'd0, "basic");
    check("basic_1234", 32'(got_w), 32'h1234);

    // Attenuation then mute
    do_frame(16'sh8000, 1'b0, 1'b0, 3'd3, "atten");
    do_frame(16'sh8000, 1'b0, 1'b1, 3'd3, "atten");
    check("atten_f000", 32'(got_w), 32'hF000);
    do_frame(16'sh0000, 1'b0, 1'b0, 3'd0, "mute");
    check("mute_zero", 32'(got_w), 32'd0);

    // Reset for one clock at cnt==130
    sound = 16'sh5555; dcblk = 1'b1; mute = 1'b0; atten = '0;
    for (int i = 0; i < 600 && tcnt != 130; i++) tick();
    check("reach_cnt130", 32'(tcnt), 32'd130);
    reset = 1'b1;
    tick();
    check("midrst_lrck", 32'(lrck_o), 32'd0);
    check("midrst_bclk", 32'(bclk_o), 32'd0);
    check("midrst_mclk", 32'(mclk_o), 32'd0);
    reset = 1'b0;
    xp = 0; yp = 0; exp_w = '0;
    do_frame(16'sh0100, 1'b1, 1'b0, 3'd0, "postrst");
    check("postrst_zero", 32'(got_w), 32'd0);
    do_frame(16'sh7FFF, 1'b1, 1'b0, 3'd0, "cleared");
    check("filter_cleared", 32'(got_w), 32'h0100);

    // Saturation in both directions
    do_frame(16'sh8000, 1'b1, 1'b0, 3'd0, "sat");
    check("sat_pos", 32'(got_w), 32'h7FFF);
    do_frame(16'sh0000, 1'b1, 1'b0, 3'd0, "sat");
    check("sat_neg", 32'(got_w), 32'h8000);

    // Randomised frames against the model
    repeat (20) begin
      do_frame(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
               3'($urandom_range(0, 7)), "rand");
    end
    do_frame(16'sh0000, 1'b0, 1'b0, 3'd0, "flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
